seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder.sv | 91 +++++++++
 tb/tb_seg7_scan_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit BCD values from a filtered, multiplexed active-low 7-segment bus
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  upd_pulse,
  output logic [2:0]            upd_idx,
  output logic                  err
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  state_t state;
  logic [6:0] r_seg, p_seg;
  logic [DIGITS-1:0] r_dig, p_dig;
  logic [CW-1:0] cnt, nc;
  logic onehot, chg, go, cap, legal, blank;
  logic [3:0] val;
  logic [2:0] idx;
  always_comb begin
    onehot = (r_dig != '0) && ((r_dig & (r_dig - DIGITS'(1))) == '0);
    chg = {r_seg, r_dig} != {p_seg, p_dig};
    go = onehot && (state != LOCKED || chg);
    nc = (state == IDLE || chg) ? CW'(1) : (cnt == SC ? cnt : cnt + 1'b1);
    cap = go && nc == SC;
    idx = '0;
    for (int k = 0; k < DIGITS; k++)
      if (r_dig[k]) idx = 3'(k);
  end
  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    val = 4'd0;
    case (r_seg)
      7'b1000000: val = 4'd0;
      7'b1111001: val = 4'd1;
      7'b0100100: val = 4'd2;
      7'b0110000: val = 4'd3;
      7'b0011001: val = 4'd4;
      7'b0010010: val = 4'd5;
      7'b0000010: val = 4'd6;
      7'b1111000: val = 4'd7;
      7'b0000000: val = 4'd8;
      7'b0010000: val = 4'd9;
      7'b1111111: begin legal = 1'b0; blank = 1'b1; end
      default:    legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      r_seg <= '0;
      r_dig <= '0;
      p_seg <= '0;
      p_dig <= '0;
      bcd_out <= '0;
      digit_valid <= '0;
      upd_pulse <= 1'b0;
      upd_idx <= '0;
      err <= 1'b0;
    end else begin
      r_seg <= seg_n;
      r_dig <= dig_sel;
      p_seg <= r_seg;
      p_dig <= r_dig;
      upd_pulse <= cap;
      err <= (err & ~err_clr) | (cap & ~legal & ~blank);
      if (!onehot) begin
        state <= IDLE;
        cnt <= '0;
      end else if (go) begin
        state <= cap ? LOCKED : SETTLE;
        cnt <= nc;
      end
      if (cap) upd_idx <= idx;
      for (int k = 0; k < DIGITS; k++)
        if (cap && r_dig[k]) begin
          if (legal) bcd_out[4*k +: 4] <= val;
          if (legal || blank) digit_valid[k] <= legal;
        end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: randomized run-length model check plus directed literal checks
module tb_seg7_scan_decoder;
  localparam int D = 4;
  localparam int S = 4;
  logic clk = 0, rst = 1, err_clr = 0;
  logic [6:0] seg_n = 7'h7f;
  logic [D-1:0] dig_sel = '0;
  logic [4*D-1:0] bcd_out;
  logic [D-1:0] digit_valid;
  logic upd_pulse, err;
  logic [2:0] upd_idx;
  int total = 0, bad = 0, pcnt = 0;
  logic [6:0] enc [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  seg7_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_sel(dig_sel), .err_clr(err_clr),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .upd_pulse(upd_pulse),
    .upd_idx(upd_idx), .err(err));

  always #5 clk = ~clk;

  function automatic int decode(input logic [6:0] s);
    for (int v = 0; v < 10; v++) if (enc[v] == s) return v;
    return (s == 7'h7f) ? 10 : 11;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: a capture fires on the edge where a one-hot sample has been seen exactly S times in a row
  int m_bcd [D];
  logic [D-1:0] m_val;
  logic m_err, m_pulse;
  int m_idx, run;
  logic [6:0] lseg;
  logic [D-1:0] ldig;
  always @(posedge clk) begin
    logic [4*D-1:0] pk;
    if (rst) begin
      foreach (m_bcd[i]) m_bcd[i] = 0;
      m_val = '0; m_err = 0; m_pulse = 0; m_idx = 0;
      lseg = '0; ldig = '0; run = 1;
    end else begin
      m_pulse = 0;
      m_err = m_err && !err_clr;
      if (run == S && $countones(ldig) == 1) begin
        int v;
        for (int i = 0; i < D; i++) if (ldig[i]) m_idx = i;
        m_pulse = 1;
        v = decode(lseg);
        if (v < 10) begin m_bcd[m_idx] = v; m_val[m_idx] = 1; end
        else if (v == 10) m_val[m_idx] = 0;
        else m_err = 1;
      end
      if (seg_n == lseg && dig_sel == ldig) run++;
      else begin run = 1; lseg = seg_n; ldig = dig_sel; end
    end
    #1;
    for (int i = 0; i < D; i++) pk[4*i +: 4] = 4'(m_bcd[i]);
    chk("bcd_out", 32'(bcd_out), 32'(pk));
    chk("digit_valid", 32'(digit_valid), 32'(m_val));
    chk("upd_pulse", 32'(upd_pulse), 32'(m_pulse));
    chk("upd_idx", 32'(upd_idx), 32'(m_idx));
    chk("err", 32'(err), 32'(m_err));
    if (upd_pulse) pcnt++;
  end

  task automatic hold(input logic [6:0] s, input logic [D-1:0] d, input int n);
    seg_n = s; dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p;
    logic [4*D-1:0] sb;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_bcd", 32'(bcd_out), 0);
    chk("reset_err", 32'(err), 0);
    p = pcnt;
    hold(enc[3], 4'b0001, 5);
    chk("t1_pulse", 32'(upd_pulse), 1);
    chk("t1_idx", 32'(upd_idx), 0);
    chk("t1_bcd", 32'(bcd_out[3:0]), 3);
    chk("t1_valid", 32'(digit_valid), 1);
    repeat (4) @(negedge clk);
    chk("t1_one_pulse", 32'(pcnt - p), 1);
    p = pcnt;
    hold(enc[1], 4'b0001, 6);
    hold(enc[9], 4'b0010, 6);
    hold(enc[0], 4'b0100, 6);
    hold(enc[7], 4'b1000, 6);
    chk("scan_bcd", 32'(bcd_out), 32'h7091);
    chk("scan_valid", 32'(digit_valid), 4'hf);
    chk("scan_pulses", 32'(pcnt - p), 4);
    hold(enc[5], 4'b0010, 3);
    hold(enc[6], 4'b0010, 1);
    p = pcnt;
    hold(enc[5], 4'b0010, 4);
    chk("glitch_wait", 32'(pcnt - p), 0);
    @(negedge clk);
    chk("glitch_cap", 32'(pcnt - p), 1);
    chk("glitch_bcd", 32'(bcd_out), 32'h7051);
    p = pcnt; sb = bcd_out;
    hold(enc[4], 4'b0101, 10);
    hold(enc[4], 4'b0000, 3);
    chk("multi_nopulse", 32'(pcnt - p), 0);
    chk("multi_bcd", 32'(bcd_out), 32'(sb));
    hold(enc[8], 4'b0100, 6);
    chk("d2_eight", 32'(bcd_out[11:8]), 8);
    hold(7'h7f, 4'b0100, 6);
    chk("blank_valid", 32'(digit_valid), 4'b1011);
    chk("blank_bcd", 32'(bcd_out[11:8]), 8);
    sb = bcd_out;
    hold(7'b1010101, 4'b0010, 6);
    chk("illegal_err", 32'(err), 1);
    chk("illegal_bcd", 32'(bcd_out), 32'(sb));
    hold(7'b1010101, 4'b1000, 4);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("clr_vs_illegal", 32'(err), 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("clr_alone", 32'(err), 0);
    hold(enc[2], 4'b0001, 2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_pulse", 32'(upd_pulse), 0);
    p = pcnt;
    repeat (4) @(negedge clk);
    chk("rst_full_wait", 32'(pcnt - p), 0);
    @(negedge clk);
    chk("rst_recap", 32'(pcnt - p), 1);
    chk("rst_recap_bcd", 32'(bcd_out[3:0]), 2);
    for (int t = 0; t < 300; t++) begin
      int len, r;
      dig_sel = ($urandom_range(0, 99) < 85) ? 4'(1 << $urandom_range(0, D - 1)) : 4'($urandom);
      r = $urandom_range(0, 9);
      seg_n = (r < 7) ? enc[$urandom_range(0, 9)] : (r < 8) ? 7'h7f : 7'($urandom);
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        err_clr = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
    end
    rst = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
